// File: rtl/video_pkg.sv
// Shared video timing definitions: default panel timing, scheduler states, frame-size helpers.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
package video_pkg;

    // Default 800x480 panel timing (pixels / lines)
    localparam int HDISP_DEF  = 800;
    localparam int VDISP_DEF  = 480;
    localparam int HFP_DEF    = 40;
    localparam int HPULSE_DEF = 48;
    localparam int HBP_DEF    = 40;
    localparam int VFP_DEF    = 13;
    localparam int VPULSE_DEF = 3;
    localparam int VBP_DEF    = 29;

    typedef enum logic [1:0] {INIT, RUN, FLUSH, REFILL} vtc_state_t;

    // Total pixel clocks per line, blanking included
    function automatic int htotal(input int hdisp, input int hfp, input int hpulse, input int hbp);
        return hfp + hpulse + hbp + hdisp;
    endfunction

    // Total lines per frame, blanking included
    function automatic int vtotal(input int vdisp, input int vfp, input int vpulse, input int vbp);
        return vfp + vpulse + vbp + vdisp;
    endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for a single level-type CDC flag.
// Latency: 2 clk cycles from input change to q.
// Backpressure: none; the flag is sampled every cycle.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; the first may go metastable, the second gives it a cycle to settle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// Pixel-domain scheduler: waits for FIFO prefill, generates HS/VS/DE and FIFO pops, recovers from underflow.
// Latency: outputs show counter position p one cycle after counters reach p; wfull rise to frame_start is 4 cycles.
// Backpressure: none toward the monitor; on FIFO underflow the frame is blanked and a stream restart is requested.
module vga_timing_ctrl
    import video_pkg::*;
#(
    parameter int HDISP  = HDISP_DEF,
    parameter int VDISP  = VDISP_DEF,
    parameter int HFP    = HFP_DEF,
    parameter int HPULSE = HPULSE_DEF,
    parameter int HBP    = HBP_DEF,
    parameter int VFP    = VFP_DEF,
    parameter int VPULSE = VPULSE_DEF,
    parameter int VBP    = VBP_DEF
) (
    input  logic        pixel_clk,
    input  logic        pixel_rst,
    input  logic        fifo_wfull,
    input  logic        fifo_rempty,
    output logic        fifo_read,
    output logic        hs,
    output logic        vs,
    output logic        de,
    output logic        frame_start,
    output logic        stream_restart,
    output logic [15:0] underflow_cnt,
    output logic [1:0]  state_o
);

    localparam int HTOTAL = htotal(HDISP, HFP, HPULSE, HBP);
    localparam int VTOTAL = vtotal(VDISP, VFP, VPULSE, VBP);
    localparam int HW     = $clog2(HTOTAL);
    localparam int VW     = $clog2(VTOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(HTOTAL - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(VTOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(HFP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(HFP + HPULSE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(VFP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(VFP + VPULSE);
    localparam logic [HW-1:0] H_ACT      = HW'(HFP + HPULSE + HBP);
    localparam logic [VW-1:0] V_ACT      = VW'(VFP + VPULSE + VBP);

    vtc_state_t    state_q, state_d;
    logic [HW-1:0] pixel_cpt;
    logic [VW-1:0] line_cpt;
    logic          wfull_s;
    logic          last_pix, last_line, frame_end, underflow;
    logic          hs_q, vs_q, de_q, frame_start_q, stream_restart_q;
    logic          hs_d, vs_d, de_d, frame_start_d, stream_restart_d;
    logic [15:0]   underflow_cnt_q;

    sync2 u_wfull_sync (
        .clk (pixel_clk),
        .rst (pixel_rst),
        .d   (fifo_wfull),
        .q   (wfull_s)
    );

    assign last_pix  = (pixel_cpt == H_LAST);
    assign last_line = (line_cpt == V_LAST);
    assign frame_end = last_pix & last_line;
    // de_q is what the sink is consuming right now, so an empty FIFO at that moment is a lost pixel
    assign underflow = (state_q == RUN) & de_q & fifo_rempty;

    // State register
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) state_q <= INIT;
        else           state_q <= state_d;
    end

    // Next state: prefill wait, scan, blank out the broken frame, then wait for a refilled FIFO
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INIT:    if (wfull_s)              state_d = RUN;
            RUN:     if (underflow)            state_d = FLUSH;
            FLUSH:   if (frame_end)            state_d = REFILL;
            REFILL:  if (frame_end && wfull_s) state_d = RUN;
            default:                           state_d = INIT;
        endcase
    end

    // Scan counters: parked at origin until the first prefill, free-running afterwards to keep the monitor locked
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            pixel_cpt <= '0;
            line_cpt  <= '0;
        end else if (state_q == INIT) begin
            pixel_cpt <= '0;
            line_cpt  <= '0;
        end else if (last_pix) begin
            pixel_cpt <= '0;
            line_cpt  <= last_line ? '0 : line_cpt + 1'b1;
        end else begin
            pixel_cpt <= pixel_cpt + 1'b1;
        end
    end

    // Position decodes; de is cut in the underflow cycle so the next pixel is already blank
    always_comb begin
        hs_d             = 1'b1;
        vs_d             = 1'b1;
        de_d             = 1'b0;
        frame_start_d    = 1'b0;
        stream_restart_d = 1'b0;
        if (state_q != INIT) begin
            hs_d             = !((pixel_cpt >= H_SYNC_BEG) && (pixel_cpt < H_SYNC_END));
            vs_d             = !((line_cpt >= V_SYNC_BEG) && (line_cpt < V_SYNC_END));
            de_d             = (state_q == RUN) && !underflow &&
                               (pixel_cpt >= H_ACT) && (line_cpt >= V_ACT);
            frame_start_d    = (pixel_cpt == '0) && (line_cpt == '0);
            stream_restart_d = (state_q == FLUSH) && frame_end;
        end
    end

    // Output registers
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            hs_q             <= 1'b1;
            vs_q             <= 1'b1;
            de_q             <= 1'b0;
            frame_start_q    <= 1'b0;
            stream_restart_q <= 1'b0;
        end else begin
            hs_q             <= hs_d;
            vs_q             <= vs_d;
            de_q             <= de_d;
            frame_start_q    <= frame_start_d;
            stream_restart_q <= stream_restart_d;
        end
    end

    // Saturating underflow event counter
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst)                                    underflow_cnt_q <= '0;
        else if (underflow && underflow_cnt_q != 16'hFFFF) underflow_cnt_q <= underflow_cnt_q + 16'd1;
    end

    // Pop in the same cycle de is shown so FIFO read data lines up with de
    assign fifo_read      = de_q;
    assign hs             = hs_q;
    assign vs             = vs_q;
    assign de             = de_q;
    assign frame_start    = frame_start_q;
    assign stream_restart = stream_restart_q;
    assign underflow_cnt  = underflow_cnt_q;
    assign state_o        = state_q;

endmodule
